// File: rtl/voting_machine_n_pkg.sv
// Shared types and helpers for the N-candidate voting machine.
package voting_pkg;

  localparam logic MODE_VOTE = 1'b0;
  localparam logic MODE_DISP = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } hold_state_e;

  // Vectors are zero-extended to 16 bits (the candidate limit) by callers.
  function automatic logic onehot_valid(input logic [15:0] vec);
    return (vec != 16'd0) && ((vec & (vec - 16'd1)) == 16'd0);
  endfunction

  function automatic int onehot_index(input logic [15:0] vec);
    int idx;
    idx = 0;
    for (int i = 15; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/voting_machine_n_if.sv
// Panel/display bundle for voting_machine_n; total exists only with VOTE_AUDIT_EN.
interface voting_machine_n_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8,
  parameter int IDX_W    = $clog2(NUM_CAND)
);
  logic                  mode;
  logic [NUM_CAND-1:0]   button;
  logic [CNT_W-1:0]      led;
  logic                  vote_pulse;
  logic                  invalid_pulse;
  logic                  sat;
  logic [IDX_W-1:0]      winner;
  logic                  tie;
`ifdef VOTE_AUDIT_EN
  logic [CNT_W+IDX_W-1:0] total;

  modport master (output mode, button,
                  input  led, vote_pulse, invalid_pulse, sat, winner, tie, total);
  modport slave  (input  mode, button,
                  output led, vote_pulse, invalid_pulse, sat, winner, tie, total);
`else
  modport master (output mode, button,
                  input  led, vote_pulse, invalid_pulse, sat, winner, tie);
  modport slave  (input  mode, button,
                  output led, vote_pulse, invalid_pulse, sat, winner, tie);
`endif
endinterface

// File: rtl/voting_machine_n_hold_detect.sv
// Press qualifier: one vote per single-button press held HOLD_CYCLES clocks.
//   state    | meaning
//   IDLE     | no button held, waiting for a press
//   HOLD     | single press latched, counting consecutive held cycles
//   WAIT_REL | press consumed or rejected, waiting for full release
module vote_hold_detect
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int IDX_W       = $clog2(NUM_CAND)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode_i,
  input  logic [NUM_CAND-1:0] button_i,
  output logic                vote_o,
  output logic [IDX_W-1:0]    vote_idx_o,
  output logic                invalid_o
);

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);

  hold_state_e         state_q, state_d;
  logic [NUM_CAND-1:0] latch_q, latch_d;
  logic [HC_W-1:0]     hcnt_q, hcnt_d;
  logic [15:0]         btn_ext;
  logic                single;
  logic                multi;

  assign btn_ext    = 16'(button_i);
  assign single     = onehot_valid(btn_ext);
  assign multi      = (button_i != '0) && !single;
  assign vote_idx_o = IDX_W'(onehot_index(16'(latch_q)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      latch_q <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_d   = latch_q;
    hcnt_d    = hcnt_q;
    vote_o    = 1'b0;
    invalid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (button_i != '0) begin
          if (mode_i == MODE_DISP) begin
            state_d = WAIT_REL;
          end else if (single) begin
            state_d = HOLD;
            latch_d = button_i;
            hcnt_d  = HC_W'(1);
          end else begin
            invalid_o = 1'b1;
            state_d   = WAIT_REL;
          end
        end
      end
      HOLD: begin
        if (button_i == '0) begin
          state_d = IDLE;
        end else if (button_i == latch_q && mode_i == MODE_VOTE) begin
          hcnt_d = hcnt_q + HC_W'(1);
          // This edge completes the HOLD_CYCLES-th held sample.
          if (hcnt_q == HC_W'(HOLD_CYCLES - 1)) begin
            vote_o  = 1'b1;
            state_d = WAIT_REL;
          end
        end else begin
          invalid_o = multi;
          state_d   = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (button_i == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/voting_machine_n.sv
// N-candidate voting machine: saturating counters, winner/tie, display mux.
// Define VOTE_AUDIT_EN to add the saturating total-vote counter.
module voting_machine_n
  import voting_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 10
) (
  input  logic               clock,
  input  logic               reset,
  voting_machine_n_if.slave  vm
);

  localparam int IDX_W = $clog2(NUM_CAND);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             vote_stb, inv_stb;
  logic [IDX_W-1:0] vote_idx;

  logic [CNT_W-1:0] cnt_q [NUM_CAND];
  logic [CNT_W-1:0] cnt_d [NUM_CAND];
  logic             sat_q, sat_d;
  logic             vote_q, inv_q;
  logic [IDX_W-1:0] win_q, win_d;
  logic             tie_q, tie_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] led_q, led_d;
  logic [CNT_W-1:0] max_c;
  int               n_max;
  logic             counted;

  vote_hold_detect #(
    .NUM_CAND    (NUM_CAND),
    .HOLD_CYCLES (HOLD_CYCLES),
    .IDX_W       (IDX_W)
  ) u_hold (
    .clock      (clock),
    .reset      (reset),
    .mode_i     (vm.mode),
    .button_i   (vm.button),
    .vote_o     (vote_stb),
    .vote_idx_o (vote_idx),
    .invalid_o  (inv_stb)
  );

  always_comb begin
    sat_d   = sat_q;
    counted = 1'b0;
    for (int i = 0; i < NUM_CAND; i++) begin
      cnt_d[i] = cnt_q[i];
      if (vote_stb && vote_idx == IDX_W'(i)) begin
        if (cnt_q[i] == CNT_MAX) begin
          sat_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
          counted  = 1'b1;
        end
      end
    end
  end

  // Strict '>' keeps the lowest index on equal counts.
  always_comb begin
    max_c = cnt_q[0];
    win_d = '0;
    n_max = 0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (cnt_q[i] > max_c) begin
        max_c = cnt_q[i];
        win_d = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cnt_q[i] == max_c) n_max = n_max + 1;
    end
    tie_d = (n_max > 1);
  end

  always_comb begin
    sel_d = sel_q;
    led_d = '0;
    if (vm.mode == MODE_DISP) begin
      if (onehot_valid(16'(vm.button))) sel_d = IDX_W'(onehot_index(16'(vm.button)));
      for (int i = 0; i < NUM_CAND; i++) begin
        if (sel_d == IDX_W'(i)) led_d = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
      sat_q  <= 1'b0;
      vote_q <= 1'b0;
      inv_q  <= 1'b0;
      win_q  <= '0;
      tie_q  <= 1'b1;
      sel_q  <= '0;
      led_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= cnt_d[i];
      sat_q  <= sat_d;
      vote_q <= vote_stb;
      inv_q  <= inv_stb;
      win_q  <= win_d;
      tie_q  <= tie_d;
      sel_q  <= sel_d;
      led_q  <= led_d;
    end
  end

  assign vm.led           = led_q;
  assign vm.vote_pulse    = vote_q;
  assign vm.invalid_pulse = inv_q;
  assign vm.sat           = sat_q;
  assign vm.winner        = win_q;
  assign vm.tie           = tie_q;

`ifdef VOTE_AUDIT_EN
  localparam int TOT_W = CNT_W + IDX_W;
  logic [TOT_W-1:0] tot_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tot_q <= '0;
    end else if (counted && tot_q != {TOT_W{1'b1}}) begin
      tot_q <= tot_q + TOT_W'(1);
    end
  end

  assign vm.total = tot_q;
`endif

endmodule

// File: tb/tb_voting_machine_n.sv
// Randomized bench for voting_machine_n against a press-history reference model.
module tb_voting_machine_n;

  localparam int NUM_CAND    = 4;
  localparam int CNT_W       = 3;
  localparam int HOLD_CYCLES = 10;
  localparam int IDX_W       = $clog2(NUM_CAND);
  localparam int CMAX        = (1 << CNT_W) - 1;
  localparam int TMAX        = (1 << (CNT_W + IDX_W)) - 1;

  logic clock;
  logic reset;

  voting_machine_n_if #(.NUM_CAND(NUM_CAND), .CNT_W(CNT_W)) vif ();

  voting_machine_n #(
    .NUM_CAND    (NUM_CAND),
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .vm    (vif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: sampled inputs since reset plus derived vote tallies.
  logic [NUM_CAND-1:0] hb[$];
  logic                hm[$];
  int cnt_m [NUM_CAND];
  int sel_m, sat_m, total_m;
  int e_vote, e_inv, e_led, e_win, e_tie;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    hb.delete();
    hm.delete();
    for (int i = 0; i < NUM_CAND; i++) cnt_m[i] = 0;
    sel_m = 0; sat_m = 0; total_m = 0;
    e_vote = 0; e_inv = 0; e_led = 0; e_win = 0; e_tie = 1;
  endtask

  // First sample of the non-zero run ending at t (looked at no further than needed).
  function automatic int run_start(input int t);
    int s;
    s = t;
    while (s > 0 && hb[s-1] != '0 && t - s <= HOLD_CYCLES) s--;
    return s;
  endfunction

  function automatic bit vote_at(input int t);
    int s;
    if ($countones(hb[t]) != 1) return 0;
    s = run_start(t);
    if (t - s + 1 != HOLD_CYCLES) return 0;
    for (int k = s; k <= t; k++) if (hb[k] != hb[t] || hm[k] != 1'b0) return 0;
    return 1;
  endfunction

  function automatic bit hold_at(input int t);
    int s;
    if (t == 0) return 0;
    if (hb[t-1] == '0) return 0;
    s = run_start(t - 1);
    if ($countones(hb[s]) != 1 || t - s >= HOLD_CYCLES) return 0;
    for (int k = s; k < t; k++) if (hb[k] != hb[s] || hm[k] != 1'b0) return 0;
    return 1;
  endfunction

  function automatic bit invalid_at(input int t);
    bit idle;
    if ($countones(hb[t]) < 2) return 0;
    idle = (t == 0) || (hb[t-1] == '0);
    return (idle && hm[t] == 1'b0) || hold_at(t);
  endfunction

  task automatic model_edge(input logic [NUM_CAND-1:0] b, input logic m);
    int t, mx, nmx, c;
    hb.push_back(b);
    hm.push_back(m);
    t = hb.size() - 1;
    e_vote = int'(vote_at(t));
    e_inv  = int'(invalid_at(t));
    mx = 0;
    for (int i = 0; i < NUM_CAND; i++) if (cnt_m[i] > mx) mx = cnt_m[i];
    nmx = 0;
    e_win = -1;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cnt_m[i] == mx) begin
        nmx++;
        if (e_win < 0) e_win = i;
      end
    end
    e_tie = (nmx > 1) ? 1 : 0;
    if (m && $countones(b) == 1) sel_m = $clog2(b);
    e_led = m ? cnt_m[sel_m] : 0;
    if (e_vote != 0) begin
      c = $clog2(b);
      if (cnt_m[c] == CMAX) sat_m = 1;
      else begin
        cnt_m[c]++;
        if (total_m < TMAX) total_m++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("vote_pulse", int'(vif.vote_pulse), e_vote);
    chk("invalid_pulse", int'(vif.invalid_pulse), e_inv);
    chk("led", int'(vif.led), e_led);
    chk("sat", int'(vif.sat), sat_m);
    chk("winner", int'(vif.winner), e_win);
    chk("tie", int'(vif.tie), e_tie);
`ifdef VOTE_AUDIT_EN
    chk("total", int'(vif.total), total_m);
`endif
  endtask

  task automatic step(input logic [NUM_CAND-1:0] b, input logic m);
    vif.button = b;
    vif.mode   = m;
    @(posedge clock);
    model_edge(b, m);
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic [NUM_CAND-1:0] b, input logic m, input int n);
    for (int i = 0; i < n; i++) step(b, m);
  endtask

  // Reset is asserted mid-cycle so clearing must come from the async path.
  task automatic apply_reset();
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic cast_vote(input int c);
    hold(NUM_CAND'(1) << c, 1'b0, HOLD_CYCLES + 1);
    hold('0, 1'b0, 1);
  endtask

  logic [NUM_CAND-1:0] rb;
  logic                rm;
  int                  r, len;

  initial begin
    reset      = 1'b1;
    vif.button = '0;
    vif.mode   = 1'b0;
    @(negedge clock);
    apply_reset();

    hold(4'b0001, 1'b0, 15);
    hold('0, 1'b0, 3);
    hold(4'b0001, 1'b0, 7);
    hold('0, 1'b0, 2);
    hold(4'b0110, 1'b0, 20);
    hold('0, 1'b0, 2);
    cast_vote(1);
    cast_vote(1);
    hold(4'b0010, 1'b1, 2);
    hold('0, 1'b1, 4);
    hold('0, 1'b0, 1);

    for (int i = 0; i < CMAX + 1; i++) cast_vote(3);
    hold(4'b1000, 1'b1, 2);
    hold(4'b1001, 1'b1, 2);
    hold('0, 1'b1, 2);
    hold('0, 1'b0, 1);

    hold(4'b0100, 1'b0, 5);
    vif.button = 4'b0100;
    apply_reset();
    hold(4'b0100, 1'b0, HOLD_CYCLES + 3);
    hold('0, 1'b0, 2);

    for (int p = 0; p < 260; p++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      rb = NUM_CAND'(1) << $urandom_range(0, NUM_CAND - 1);
      else if (r < 85) rb = NUM_CAND'($urandom_range(0, (1 << NUM_CAND) - 1));
      else             rb = '0;
      rm  = ($urandom_range(0, 99) < 15);
      len = int'($urandom_range(1, 16));
      if ($urandom_range(0, 9) == 0) begin
        hold(rb, rm, len / 2 + 1);
        hold(rb, ~rm, len / 2 + 1);
      end else begin
        hold(rb, rm, len);
      end
      hold('0, rm, int'($urandom_range(0, 3)));
    end

    for (int c = 0; c < NUM_CAND; c++) hold(NUM_CAND'(1) << c, 1'b1, 2);
    hold('0, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/voting_machine_n.md
Name: voting_machine_n

Overview:
- Parametrised successor to the 4-button voting machine.
- Supports NUM_CAND candidates with per-candidate counters of width CNT_W.
- A vote counts only when exactly one button is held for HOLD_CYCLES clocks. Simultaneous presses are rejected and flagged.
- Display mode shows the selected candidate's count on led. A registered winner/tie indication is produced continuously.
- Sits between the debounced panel buttons and the display/LED driver.

Parameters:
- NUM_CAND, 4, number of candidates/buttons (2..16).
- CNT_W, 8, per-candidate vote counter width; also the led width.
- HOLD_CYCLES, 10, consecutive cycles a single press must be held to register one vote (>=2).
- IDX_W, $clog2(NUM_CAND), derived; width of the winner index.

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- mode, input, 1, 0 = vote, 1 = display.
- button, input, NUM_CAND, one bit per candidate, active-high, already synchronised.
- led, output, CNT_W, display-mode count of the selected candidate; 0 in vote mode.
- vote_pulse, output, 1, one-cycle pulse when a vote is recorded.
- invalid_pulse, output, 1, one-cycle pulse when a multi-button press is rejected.
- sat, output, 1, sticky flag: some counter has saturated.
- winner, output, IDX_W, index of the highest count; ties go to the lowest index.
- tie, output, 1, set when the maximum count is shared by more than one candidate.
- total, output, CNT_W+IDX_W, total recorded votes; present only with VOTE_AUDIT_EN.

Behaviour:
- Reset (reset=0, async):
  - Counts, led, vote_pulse, invalid_pulse, sat, winner, total all cleared to 0.
  - tie=1, since all counts are equal.
  - FSM goes to IDLE; selected index = 0.
- FSM in sub-module vote_hold_detect, states IDLE, HOLD, WAIT_REL:
  - IDLE: button==0 stays. Exactly one bit set with mode=0 goes to HOLD: latch the one-hot vector, hold_cnt=1. More than one bit set: invalid_pulse=1 next cycle, go to WAIT_REL. Any press with mode=1 goes to WAIT_REL with no vote and no invalid.
  - HOLD: button equals the latched vector and mode=0: hold_cnt increments. When hold_cnt reaches HOLD_CYCLES, fire the vote and go to WAIT_REL.
  - HOLD with button==0 (early release) goes to IDLE; no vote, no pulse.
  - HOLD with a changed vector: if more than one bit is set, invalid_pulse and go to WAIT_REL. Otherwise (different single bit, or mode goes to 1) abort to WAIT_REL with no pulse.
  - WAIT_REL: stay until button==0, then IDLE. Exactly one vote per press regardless of hold length.
- Vote latency:
  - vote_pulse is high for the one cycle after the edge where hold_cnt reaches HOLD_CYCLES.
  - The candidate count increments on that same edge.
  - With defaults, a press sampled on edges 1..10 produces the pulse after edge 10.
- Counters saturate at 2^CNT_W-1. Further votes for that candidate still pulse vote_pulse; the count is unchanged and sat is set (sticky until reset).
- Winner logic:
  - Compare all registered counts; register winner/tie one cycle after a count changes.
  - Ties resolve to the lowest index; tie=1 when two or more candidates hold the maximum (including the all-zero case).
- Display (mode=1):
  - A one-hot button vector updates the selected index.
  - No press or a multi-bit press holds the previous selection.
  - led = count[selected], registered with 1-cycle latency; it tracks count changes.
- Vote mode: led = 0, registered.
- Mode change: switching mode mid-HOLD aborts the vote as above. Counts are never altered by display mode.

Optional Feature:
- VOTE_AUDIT_EN defined:
  - A total counter of width CNT_W+IDX_W increments on every recorded vote that is not suppressed by saturation.
  - It saturates at its maximum and drives the total port.
  - Invariant: total equals the sum of the counts.
- VOTE_AUDIT_EN undefined: no total register and no total port.

Decomposition:
- Package voting_pkg:
  - MODE_VOTE=1'b0, MODE_DISP=1'b1.
  - FSM state enum (IDLE, HOLD, WAIT_REL).
  - Function onehot_valid(vector).
- Sub-module vote_hold_detect:
  - Contains the FSM and hold counter.
  - Outputs a vote strobe, the vote index and an invalid strobe.
- Top level holds the counters, saturation, winner compare, display mux and audit counter.

Test Plan:
- Reset, then hold button[0] for 15 cycles in mode 0 -> exactly one vote_pulse; count0=1; winner=0, tie=0 one cycle later.
- Hold button[0] for 7 cycles, then release -> no vote_pulse; count0 unchanged.
- Press button[1] and button[2] together for 20 cycles -> one invalid_pulse; counts unchanged; no vote until both are released.
- Record votes 0,1,1, then mode=1 and press button[1] for 2 cycles -> led=2 and holds after release; winner=1, tie=0.
- With CNT_W=2, cast 4 votes for candidate 3 -> count3=3, sat=1, 4 vote_pulses; under VOTE_AUDIT_EN total=3.
- Assert reset low while in HOLD -> all outputs cleared asynchronously; the next press requires the full HOLD_CYCLES again.
